// File: rtl/ysyx_22050133_axi_pkg.sv
// Shared definitions for the simplified AXI-style rw bus.
// Holds the size/burst encodings, the responder state enum and the size-to-mask helper.
package ysyx_22050133_axi_pkg;

    localparam int AXI_DATA_W = 64;
    localparam int AXI_ADDR_W = 32;

    localparam logic [2:0] AXI_SIZE_BYTES_1 = 3'd0;
    localparam logic [2:0] AXI_SIZE_BYTES_2 = 3'd1;
    localparam logic [2:0] AXI_SIZE_BYTES_4 = 3'd2;
    localparam logic [2:0] AXI_SIZE_BYTES_8 = 3'd3;

    localparam logic [1:0] BURST_TYPE_FIXED = 2'd0;
    localparam logic [1:0] BURST_TYPE_INCR  = 2'd1;
    localparam logic [1:0] BURST_TYPE_WRAP  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W    = 2'd1,
        S_R    = 2'd2
    } mem_state_e;

    // Mask covering the low (1<<size) bytes of a 64-bit beat; sizes of 8 bytes or more keep all lanes.
    function automatic logic [63:0] size_to_mask(input logic [2:0] size);
        logic [63:0] mask;
        case (size)
            AXI_SIZE_BYTES_1: mask = 64'h0000_0000_0000_00FF;
            AXI_SIZE_BYTES_2: mask = 64'h0000_0000_0000_FFFF;
            AXI_SIZE_BYTES_4: mask = 64'h0000_0000_FFFF_FFFF;
            default:          mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ysyx_22050133_mem_responder_if.sv
// Bus bundle between an rw initiator (cache / uncached path) and the memory responder.
// Signal names carry the responder's point of view (_i into it, _o out of it).
interface ysyx_22050133_mem_responder_if;
    import ysyx_22050133_axi_pkg::*;

    logic                  rw_addr_valid_i;
    logic                  rw_addr_ready_o;
    logic [AXI_ADDR_W-1:0] rw_addr_i;
    logic                  rw_we_i;
    logic [7:0]            rw_len_i;
    logic [2:0]            rw_size_i;
    logic [1:0]            rw_burst_i;
    logic                  rw_if_i;
    logic                  w_data_valid_i;
    logic                  w_data_ready_o;
    logic [AXI_DATA_W-1:0] w_data_i;
    logic                  r_data_valid_o;
    logic                  r_data_ready_i;
    logic [AXI_DATA_W-1:0] r_data_o;

    modport master (
        output rw_addr_valid_i, rw_addr_i, rw_we_i, rw_len_i, rw_size_i, rw_burst_i, rw_if_i,
        output w_data_valid_i, w_data_i, r_data_ready_i,
        input  rw_addr_ready_o, w_data_ready_o, r_data_valid_o, r_data_o
    );

    modport slave (
        input  rw_addr_valid_i, rw_addr_i, rw_we_i, rw_len_i, rw_size_i, rw_burst_i, rw_if_i,
        input  w_data_valid_i, w_data_i, r_data_ready_i,
        output rw_addr_ready_o, w_data_ready_o, r_data_valid_o, r_data_o
    );

endinterface

// File: rtl/ysyx_22050133_lfsr8.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), right-shifting, loaded with SEED on reset.
// SEED must be nonzero or the register sticks at zero.
module ysyx_22050133_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    localparam logic [7:0] TAPS = 8'hB8;

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Each bit takes its upper neighbour, xored with the feedback bit where a tap sits.
    for (genvar gi = 0; gi < 8; gi++) begin : g_fb
        if (gi == 7) begin : g_top
            assign q_d[gi] = TAPS[gi] & q_q[0];
        end else begin : g_mid
            assign q_d[gi] = q_q[gi+1] ^ (TAPS[gi] & q_q[0]);
        end
    end

    // Shift register, advancing every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ysyx_22050133_mem_responder.sv
// Burst-capable memory responder for the rw bus: one address phase at a time, then
// sinks write beats or sources read beats from an internal 64-bit word array.
// Optional feature macro: YSYX_22050133_MEM_STALL_EN (LFSR-driven random wait states).
module ysyx_22050133_mem_responder
    import ysyx_22050133_axi_pkg::*;
#(
    parameter int         RW_DATA_WIDTH  = 64,
    parameter int         RW_ADDR_WIDTH  = 32,
    parameter int         MEM_WORDS_LOG2 = 12,
    parameter logic [7:0] STALL_SEED     = 8'hA5
) (
    input logic                          clk,
    input logic                          rst,
    ysyx_22050133_mem_responder_if.slave bus
);

    localparam int MEM_WORDS = 1 << MEM_WORDS_LOG2;
    localparam int IW        = MEM_WORDS_LOG2;

    mem_state_e               state_q, state_d;
    logic [RW_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic                     if_q, if_d;

    logic [RW_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [RW_DATA_WIDTH-1:0] rdata_q;

    logic                     stall;
    logic                     addr_ready;
    logic                     w_ready;
    logic                     r_valid;
    logic                     addr_hs;
    logic                     w_hs;
    logic                     r_hs;
    logic [RW_ADDR_WIDTH-1:0] addr_next;
    logic [IW-1:0]            wr_idx;
    logic [IW-1:0]            rd_idx;
    logic                     rd_en;
    logic                     mem_we;
    logic [7:0]               wr_be;
    logic [8:0]               lane_end;
    logic [RW_DATA_WIDTH-1:0] wdata_sh;

    assign addr_ready = (state_q == S_IDLE);
    assign w_ready    = (state_q == S_W) && !stall;

    assign addr_hs = bus.rw_addr_valid_i & addr_ready;
    assign w_hs    = bus.w_data_valid_i & w_ready;
    assign r_hs    = r_valid & bus.r_data_ready_i;

    // FIXED bursts revisit the same address; INCR and WRAP both step linearly.
    assign addr_next = (burst_q == BURST_TYPE_FIXED) ? addr_q
                                                     : addr_q + (RW_ADDR_WIDTH'(1) << size_q);

    // Write path: byte lanes from the beat offset up to offset+(1<<size)-1, clipped at lane 7.
    assign wr_idx   = addr_q[IW+2:3];
    assign lane_end = 9'(addr_q[2:0]) + (9'd1 << size_q);
    assign wdata_sh = bus.w_data_i << {addr_q[2:0], 3'b000};
    assign mem_we   = w_hs & ~rst;

    for (genvar gi = 0; gi < 8; gi++) begin : g_be
        assign wr_be[gi] = (9'(gi) >= 9'(addr_q[2:0])) && (9'(gi) < lane_end);
    end

    // Read path: the word for the next beat is fetched on the edge that makes it current,
    // either the address handshake or the previous beat's handshake.
    assign rd_en  = (addr_hs & ~bus.rw_we_i) | (r_hs & (cnt_q != 8'd0));
    assign rd_idx = addr_hs ? bus.rw_addr_i[IW+2:3] : addr_next[IW+2:3];

`ifdef YSYX_22050133_MEM_STALL_EN
    logic [7:0] lfsr_q;
    logic       r_hold_q;
    logic       unused_bits;

    ysyx_22050133_lfsr8 #(
        .SEED (STALL_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign stall = (lfsr_q[1:0] == 2'b00);

    // Remember a presented-but-unaccepted read beat so the gate cannot withdraw it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_q <= 1'b0;
        end else begin
            r_hold_q <= r_valid & ~bus.r_data_ready_i;
        end
    end

    assign r_valid     = (state_q == S_R) && (r_hold_q || !stall);
    assign unused_bits = ^{if_q, lfsr_q[7:2]};
`else
    logic unused_bits;

    assign stall       = 1'b0;
    assign r_valid     = (state_q == S_R);
    assign unused_bits = ^{if_q, STALL_SEED};
`endif

    // Array write with per-byte enables; not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
                end
            end
        end
    end

    // Registered array read feeding the current read beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

    // State and transaction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            size_q  <= 3'd0;
            burst_q <= 2'd0;
            if_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            if_q    <= if_d;
        end
    end

    // Next-state logic: latch on address handshake, count beats, return to idle after the last.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        burst_d = burst_q;
        if_d    = if_q;
        case (state_q)
            S_IDLE: begin
                if (addr_hs) begin
                    addr_d  = bus.rw_addr_i;
                    cnt_d   = bus.rw_len_i;
                    size_d  = bus.rw_size_i;
                    burst_d = bus.rw_burst_i;
                    if_d    = bus.rw_if_i;
                    state_d = bus.rw_we_i ? S_W : S_R;
                end
            end
            S_W: begin
                if (w_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            S_R: begin
                if (r_hs) begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d  = cnt_q - 8'd1;
                        addr_d = addr_next;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rw_addr_ready_o = addr_ready;
    assign bus.w_data_ready_o  = w_ready;
    assign bus.r_data_valid_o  = r_valid;
    assign bus.r_data_o        = r_valid ? ((rdata_q >> {addr_q[2:0], 3'b000}) & size_to_mask(size_q))
                                         : '0;

endmodule

// File: tb/tb_ysyx_22050133_mem_responder.sv
// Self-checking bench for the rw-bus memory responder. A byte-level memory model
// predicts every read beat; per-scenario tasks drive the bus and compare inline.
module tb_ysyx_22050133_mem_responder;
    import ysyx_22050133_axi_pkg::*;

    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050133_mem_responder_if bus();

    ysyx_22050133_mem_responder #(
        .RW_DATA_WIDTH  (64),
        .RW_ADDR_WIDTH  (32),
        .MEM_WORDS_LOG2 (12),
        .STALL_SEED     (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int timeouts   = 0;
    int hold_viol  = 0;
    int rd_cycles  = 0;

    logic [63:0] mdl [int];
    logic [63:0] rd_beats [$];
    logic [63:0] wr_q [$];
    logic        post_addr_ready;
    logic        post_addr_first;
    logic        post_end_ready;

    // ---------------- reference model ----------------
    function automatic int widx(input logic [31:0] a);
        return int'((a >> 3) & 32'hFFF);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == BURST_TYPE_FIXED) ? a : a + (32'd1 << size);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [2:0] size,
                                        input logic [63:0] d);
        int n = 1 << size;
        int off = int'(a[2:0]);
        logic [63:0] w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
        for (int b = 0; b < n; b++) begin
            if (off + b < 8) w[(off+b)*8 +: 8] = d[b*8 +: 8];
        end
        mdl[widx(a)] = w;
    endfunction

    function automatic logic [63:0] model_read(input logic [31:0] a, input logic [2:0] size);
        int n = 1 << size;
        int off = int'(a[2:0]);
        logic [63:0] w = mdl.exists(widx(a)) ? mdl[widx(a)] : 64'h0;
        logic [63:0] r = 64'h0;
        for (int b = 0; b < n; b++) begin
            if (off + b < 8) r[b*8 +: 8] = w[(off+b)*8 +: 8];
        end
        return r;
    endfunction

    // ---------------- bus drivers (called just after a falling edge) ----------------
    task automatic addr_phase(input logic [31:0] a, input logic we, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        bus.rw_addr_valid_i = 1'b1;
        bus.rw_addr_i       = a;
        bus.rw_we_i         = we;
        bus.rw_len_i        = len;
        bus.rw_size_i       = size;
        bus.rw_burst_i      = burst;
        bus.rw_if_i         = 1'($urandom % 2);
        while (bus.rw_addr_ready_o !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TO) timeouts++;
        @(negedge clk);
        bus.rw_addr_valid_i = 1'b0;
        bus.rw_addr_i       = $urandom;
        bus.rw_we_i         = 1'($urandom % 2);
        post_addr_ready     = bus.rw_addr_ready_o;
        post_addr_first     = we ? bus.w_data_ready_o : bus.r_data_valid_o;
    endtask

    task automatic write_beat(input logic [63:0] d);
        int n = 0;
        bus.w_data_valid_i = 1'b1;
        bus.w_data_i       = d;
        while (bus.w_data_ready_o !== 1'b1 && n < TO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TO) timeouts++;
        @(negedge clk);
        bus.w_data_valid_i = 1'b0;
        bus.w_data_i       = {$urandom, $urandom};
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst);
        logic [31:0] cur = a;
        addr_phase(a, 1'b1, len, size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            write_beat(wr_q[k]);
            model_write(cur, size, wr_q[k]);
            cur = next_addr(cur, size, burst);
        end
        post_end_ready = bus.rw_addr_ready_o;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int drop_beat, input bit rand_ready);
        logic [63:0] cap;
        int          hold;
        int          n;
        rd_beats.delete();
        rd_cycles = 0;
        addr_phase(a, 1'b0, len, size, burst);
        for (int k = 0; k <= int'(len); k++) begin
            n = 0;
            while (bus.r_data_valid_o !== 1'b1 && n < TO) begin
                bus.r_data_ready_i = rand_ready ? 1'($urandom % 2) : 1'b1;
                @(negedge clk);
                n++;
                rd_cycles++;
            end
            if (n >= TO) timeouts++;
            cap = bus.r_data_o;
            rd_beats.push_back(cap);
            hold = (k == drop_beat) ? 3 : (rand_ready ? int'($urandom_range(0, 2)) : 0);
            bus.r_data_ready_i = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                rd_cycles++;
                if (bus.r_data_valid_o !== 1'b1 || bus.r_data_o !== cap) hold_viol++;
            end
            bus.r_data_ready_i = 1'b1;
            @(negedge clk);
            rd_cycles++;
        end
        bus.r_data_ready_i = 1'b0;
        post_end_ready = bus.rw_addr_ready_o;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.rw_addr_valid_i = 1'b0;
        bus.rw_addr_i       = '0;
        bus.rw_we_i         = 1'b0;
        bus.rw_len_i        = '0;
        bus.rw_size_i       = '0;
        bus.rw_burst_i      = '0;
        bus.rw_if_i         = 1'b0;
        bus.w_data_valid_i  = 1'b0;
        bus.w_data_i        = '0;
        bus.r_data_ready_i  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++; if (bus.rw_addr_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_addr_ready: got %b expected 1", bus.rw_addr_ready_o); end
        vectors++; if (bus.w_data_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_w_ready: got %b expected 0", bus.w_data_ready_o); end
        vectors++; if (bus.r_data_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_r_valid: got %b expected 0", bus.r_data_valid_o); end
        vectors++; if (bus.r_data_o !== 64'h0) begin miscompares++; $display("FAIL reset_r_data: got %h expected 0", bus.r_data_o); end
        // Stray beat signals while idle must not start anything.
        bus.w_data_valid_i = 1'b1;
        bus.r_data_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.w_data_valid_i = 1'b0;
        bus.r_data_ready_i = 1'b0;
        vectors++; if (bus.rw_addr_ready_o !== 1'b1 || bus.r_data_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL idle_foreign: got ready=%b valid=%b expected ready=1 valid=0", bus.rw_addr_ready_o, bus.r_data_valid_o);
        end
    endtask

    task automatic test_single_read();
        wr_q = '{64'h1122334455667788};
        bus_write(32'h80, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
`ifndef YSYX_22050133_MEM_STALL_EN
        vectors++; if (post_addr_first !== 1'b1) begin miscompares++; $display("FAIL wr_first_ready_latency: got %b expected 1", post_addr_first); end
`endif
        bus_read(32'h80, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, -1, 1'b0);
        vectors++; if (post_addr_ready !== 1'b0) begin miscompares++; $display("FAIL addr_ready_busy: got %b expected 0", post_addr_ready); end
`ifndef YSYX_22050133_MEM_STALL_EN
        vectors++; if (post_addr_first !== 1'b1) begin miscompares++; $display("FAIL rd_first_valid_latency: got %b expected 1", post_addr_first); end
`endif
        vectors++; if (rd_beats[0] !== 64'h1122334455667788) begin miscompares++; $display("FAIL single_read: got %h expected %h", rd_beats[0], 64'h1122334455667788); end
        vectors++; if (post_end_ready !== 1'b1) begin miscompares++; $display("FAIL single_read_idle: got %b expected 1", post_end_ready); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp;
        wr_q.delete();
        for (int k = 0; k < 8; k++) wr_q.push_back(64'(k));
        bus_write(32'h100, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        vectors++; if (post_end_ready !== 1'b1) begin miscompares++; $display("FAIL burst_write_idle: got %b expected 1", post_end_ready); end
        bus_read(32'h100, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, 4, 1'b0);
        vectors++; if (rd_beats.size() !== 8) begin miscompares++; $display("FAIL burst_beats: got %0d expected 8", rd_beats.size()); end
        for (int k = 0; k < 8 && k < rd_beats.size(); k++) begin
            exp = 64'(k);
            vectors++; if (rd_beats[k] !== exp) begin miscompares++; $display("FAIL burst_read beat %0d: got %h expected %h", k, rd_beats[k], exp); end
        end
        vectors++; if (hold_viol !== 0) begin miscompares++; $display("FAIL burst_hold_stable: got %0d expected 0", hold_viol); end
`ifndef YSYX_22050133_MEM_STALL_EN
        // Zero-wait read of 8 beats with ready held high: one beat per cycle.
        bus_read(32'h100, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, -1, 1'b0);
        vectors++; if (rd_cycles !== 8) begin miscompares++; $display("FAIL read_throughput: got %0d expected 8", rd_cycles); end
`endif
    endtask

    task automatic test_narrow();
        logic [63:0] d;
        wr_q = '{64'h0};
        bus_write(32'h200, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        d = {$urandom, $urandom};
        d[7:0] = 8'hAB;
        wr_q = '{d};
        bus_write(32'h203, 8'd0, AXI_SIZE_BYTES_1, BURST_TYPE_INCR);
        bus_read(32'h200, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, -1, 1'b0);
        vectors++; if (rd_beats[0] !== 64'h00000000AB000000) begin miscompares++; $display("FAIL narrow_word: got %h expected %h", rd_beats[0], 64'h00000000AB000000); end
        bus_read(32'h203, 8'd0, AXI_SIZE_BYTES_1, BURST_TYPE_INCR, -1, 1'b0);
        vectors++; if (rd_beats[0] !== 64'hAB) begin miscompares++; $display("FAIL narrow_byte: got %h expected %h", rd_beats[0], 64'hAB); end
    endtask

    task automatic test_fixed();
        logic [63:0] exp;
        wr_q = '{{$urandom, $urandom}};
        bus_write(32'h40, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        wr_q = '{{$urandom, $urandom}};
        bus_write(32'h48, 8'd0, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        exp = model_read(32'h40, AXI_SIZE_BYTES_8);
        bus_read(32'h40, 8'd3, AXI_SIZE_BYTES_8, BURST_TYPE_FIXED, -1, 1'b0);
        vectors++; if (rd_beats.size() !== 4) begin miscompares++; $display("FAIL fixed_beats: got %0d expected 4", rd_beats.size()); end
        for (int k = 0; k < rd_beats.size(); k++) begin
            vectors++; if (rd_beats[k] !== exp) begin miscompares++; $display("FAIL fixed_read beat %0d: got %h expected %h", k, rd_beats[k], exp); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] d;
        logic [63:0] exp;
        logic [31:0] cur;
        wr_q.delete();
        for (int k = 0; k < 8; k++) wr_q.push_back({$urandom, $urandom});
        bus_write(32'h300, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        addr_phase(32'h300, 1'b1, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        for (int k = 0; k < 3; k++) begin
            d = {$urandom, $urandom};
            write_beat(d);
            model_write(32'h300 + 32'(k * 8), AXI_SIZE_BYTES_8, d);
        end
        bus.w_data_valid_i = 1'b1;
        bus.w_data_i       = {$urandom, $urandom};
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.w_data_valid_i = 1'b0;
        vectors++; if (bus.rw_addr_ready_o !== 1'b1) begin miscompares++; $display("FAIL abort_addr_ready: got %b expected 1", bus.rw_addr_ready_o); end
        vectors++; if (bus.w_data_ready_o !== 1'b0) begin miscompares++; $display("FAIL abort_w_ready: got %b expected 0", bus.w_data_ready_o); end
        vectors++; if (bus.r_data_valid_o !== 1'b0 || bus.r_data_o !== 64'h0) begin
            miscompares++; $display("FAIL abort_r_out: got valid=%b data=%h expected 0/0", bus.r_data_valid_o, bus.r_data_o);
        end
        bus_read(32'h300, 8'd7, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, -1, 1'b0);
        cur = 32'h300;
        for (int k = 0; k < rd_beats.size(); k++) begin
            exp = model_read(cur, AXI_SIZE_BYTES_8);
            vectors++; if (rd_beats[k] !== exp) begin miscompares++; $display("FAIL abort_contents word %0d: got %h expected %h", k, rd_beats[k], exp); end
            cur = next_addr(cur, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        end
    endtask

    task automatic test_random_refills();
        logic [31:0] a, cur;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [63:0] exp;
        // Fill a 256-word region with the longest burst, read it back through an aliased address.
        wr_q.delete();
        for (int k = 0; k < 256; k++) wr_q.push_back({$urandom, $urandom});
        bus_write(32'h1000, 8'd255, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        bus_read(32'h9000, 8'd255, AXI_SIZE_BYTES_8, BURST_TYPE_INCR, -1, 1'b1);
        vectors++; if (rd_beats.size() !== 256) begin miscompares++; $display("FAIL long_burst_beats: got %0d expected 256", rd_beats.size()); end
        cur = 32'h1000;
        for (int k = 0; k < rd_beats.size(); k++) begin
            exp = model_read(cur, AXI_SIZE_BYTES_8);
            vectors++; if (rd_beats[k] !== exp) begin miscompares++; $display("FAIL long_burst beat %0d: got %h expected %h", k, rd_beats[k], exp); end
            cur = next_addr(cur, AXI_SIZE_BYTES_8, BURST_TYPE_INCR);
        end
        // Mixed cache-line refills / writebacks and random narrow traffic.
        for (int it = 0; it < 40; it++) begin
            if (it % 2 == 0) begin
                a = 32'h1000 + ($urandom_range(0, 31) << 6);
                len = 8'd7; size = AXI_SIZE_BYTES_8; burst = BURST_TYPE_INCR;
            end else begin
                a = 32'h1000 + $urandom_range(0, 32'h5FF);
                len = 8'($urandom_range(0, 7));
                size = 3'($urandom_range(0, 3));
                burst = 2'($urandom_range(0, 2));
            end
            if ($urandom % 2 == 0) begin
                wr_q.delete();
                for (int k = 0; k <= int'(len); k++) wr_q.push_back({$urandom, $urandom});
                bus_write(a, len, size, burst);
            end else begin
                bus_read(a, len, size, burst, -1, 1'b1);
                cur = a;
                for (int k = 0; k < rd_beats.size(); k++) begin
                    exp = model_read(cur, size);
                    vectors++; if (rd_beats[k] !== exp) begin
                        miscompares++; $display("FAIL refill it %0d beat %0d addr %h: got %h expected %h", it, k, cur, rd_beats[k], exp);
                    end
                    cur = next_addr(cur, size, burst);
                end
            end
        end
        vectors++; if (hold_viol !== 0) begin miscompares++; $display("FAIL valid_withdrawn: got %0d expected 0", hold_viol); end
        vectors++; if (timeouts !== 0) begin miscompares++; $display("FAIL handshake_timeout: got %0d expected 0", timeouts); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_narrow();
        test_fixed();
        test_reset_mid_burst();
        test_random_refills();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ysyx_22050133_mem_responder.md
# ysyx_22050133_mem_responder

Burst-capable memory responder for the simplified AXI-style rw bus that the cache and uncached paths drive as initiator. It accepts one address-phase transaction at a time, sinks write bursts or sources read bursts beat by beat, and serves them from an internal doubleword array. It stands in for main memory in NPC simulation and lets the bench stress cache refill and writeback.

## Interface
- RW_DATA_WIDTH, 64, data beat width; only 64 is supported.
- RW_ADDR_WIDTH, 32, byte address width.
- MEM_WORDS_LOG2, 12, log2 of the number of 64-bit words in the array.
- STALL_SEED, 8'hA5, nonzero LFSR seed; used only with the stall feature.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- rw_addr_valid_i  in  1  address-phase valid.
- rw_addr_ready_o  out  1  address-phase ready.
- rw_addr_i  in  32  start byte address.
- rw_we_i  in  1  1 = write burst, 0 = read burst.
- rw_len_i  in  8  number of beats minus 1.
- rw_size_i  in  3  bytes per beat = 1<<size.
- rw_burst_i  in  2  FIXED / INCR; WRAP is treated as INCR.
- rw_if_i  in  1  instruction-fetch tag; recorded only.
- w_data_valid_i  in  1  write beat valid.
- w_data_ready_o  out  1  write beat ready.
- w_data_i  in  64  write data, right-justified.
- r_data_valid_o  out  1  read beat valid.
- r_data_ready_i  in  1  read beat ready.
- r_data_o  out  64  read data, right-justified and masked to the size.

## Operation
- States:
  - S_IDLE: rw_addr_ready_o=1. An address handshake latches addr, we, len, size, burst and if.
  - Next state after the handshake: we=1 → S_W; we=0 → S_R.
- S_W:
  - w_data_ready_o=1.
  - Each beat with valid&ready writes byte lanes addr[2:0]..addr[2:0]+(1<<size)-1 of word mem[addr[MEM_WORDS_LOG2+2:3]], using data w_data_i<<(addr[2:0]*8).
  - Then the beat counter decrements and the address advances.
  - After the beat with counter==0 → S_IDLE.
- S_R:
  - r_data_valid_o=1, r_data_o=(mem[idx]>>(addr[2:0]*8)) & size mask.
  - Valid and data are held stable until r_data_ready_i.
  - After a handshake with counter==0 → S_IDLE. Otherwise the counter decrements, the address advances, and the next beat's data appears the following cycle.
- Address advance:
  - INCR/WRAP: addr += 1<<size.
  - FIXED: unchanged.
  - Arithmetic is 32-bit, wrapping.
  - The array index wraps modulo 2^MEM_WORDS_LOG2; no error response.
- Beat counter: 8-bit. len=0 gives exactly one beat; len=255 gives 256 beats.
- Foreign signals are ignored:
  - w_data_valid_i while in S_IDLE/S_R.
  - r_data_ready_i while in S_IDLE/S_W.
  - rw_addr_valid_i while busy.
- The memory array is never cleared by reset. A $readmemh preload is allowed in simulation.

## Timing
- Reset values: rw_addr_ready_o=1, w_data_ready_o=0, r_data_valid_o=0, r_data_o=0, state=S_IDLE, counter=0.
- Address handshake in cycle N:
  - rw_addr_ready_o=0 from N+1.
  - First read valid, or first write ready, in N+1 (no stall).
- Read throughput: 1 beat/cycle when ready is held high.
- End of burst: after the last beat's handshake in cycle M, the responder is in S_IDLE with rw_addr_ready_o=1 in M+1. A new address can be accepted in M+1.
- Rst asserted mid-burst: abort at the next edge, all outputs go to reset values, and partial writes already committed remain.
- Read-after-write to the same word in consecutive transactions returns the new data; the write commits at the edge of the handshake.

## Configuration
- YSYX_22050133_MEM_STALL_EN defined:
  - An 8-bit LFSR (seeded by STALL_SEED, advancing every cycle) gates w_data_ready_o and r_data_valid_o.
  - When LFSR[1:0]==0 the handshake output is forced low that cycle.
  - A read beat whose valid is already high is never withdrawn. Gating applies only to raising valid for a new beat.
- Undefined: zero-wait behaviour exactly as in Timing; the LFSR is not instantiated.

## Structure
- Shared package ysyx_22050133_axi_pkg:
  - AXI_SIZE_BYTES_1/2/4/8 and BURST_TYPE_FIXED/INCR/WRAP constants.
  - The state enum.
  - The size-to-mask function, also usable by the cache.
- One sub-module: ysyx_22050133_lfsr8, a Galois LFSR with seed parameter, rst, clk and q[7:0]. It is instantiated only under YSYX_22050133_MEM_STALL_EN.

## Test plan
- Preload mem[0x10]=64'h1122334455667788. Read addr 0x80, len 0, size 8 → one beat 64'h1122334455667788, then the responder is back in S_IDLE.
- Write burst addr 0x100, len 7, INCR, data 0..7. Then read the same burst → beats 0..7 in order. Drop ready for 3 cycles on beat 4 → data is held stable.
- Narrow write size 1 at 0x203, data 0xAB, onto a word of all zeros. Read size 8 at 0x200 → 64'h00000000AB000000. Read size 1 at 0x203 → 0xAB.
- FIXED read len 3 at 0x40 → four identical beats.
- Assert rst on beat 3 of an 8-beat write → outputs reset next cycle, words 0-2 are written, words 3-7 are unchanged, and a new transaction is accepted.
- With YSYX_22050133_MEM_STALL_EN, run random 8-beat cache refills → data matches the reference model and no valid is withdrawn.
